dmem_arbiter: RTL and testbench

//  Shares one 32-bit data memory between two requesters: A (core LSU) and B (debug/loader port).
//  The memory is four byte-lane BRAM banks that capture write data and read data on the negative clock edge.

---
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one four-bank byte-lane data memory between a core LSU (A)
// and a debug/loader port (B). One registered access every two cycles; loads return after one cycle.

module dmem_lane (
    input  logic in_range,
    input  logic we,
    input  logic be,
    output logic wr_en,
    output logic rd_en
);
    assign wr_en = in_range & we & be;
    assign rd_en = in_range & ~we;
endmodule

module dmem_arbiter #(
    parameter int          ADDR_WIDTH = 13,
    parameter int unsigned MEM_WORDS  = 2**(ADDR_WIDTH-3)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  A_REQ,
    input  logic                  A_WE,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [3:0]            A_BE,
    input  logic [31:0]           A_WDATA,
    output logic                  A_GNT,
    output logic                  A_RVALID,
    output logic [31:0]           A_RDATA,
    output logic                  A_ERR,
    input  logic                  B_REQ,
    input  logic                  B_WE,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [3:0]            B_BE,
    input  logic [31:0]           B_WDATA,
    output logic                  B_GNT,
    output logic                  B_RVALID,
    output logic [31:0]           B_RDATA,
    output logic                  B_ERR,
    output logic [ADDR_WIDTH-1:0] MEM_W_ADDR,
    output logic [ADDR_WIDTH-1:0] MEM_R_ADDR,
    output logic [3:0]            MEM_WRITE_EN,
    output logic [3:0]            MEM_READ_EN,
    output logic [31:0]           MEM_DIN,
    input  logic [31:0]           MEM_DOUT
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int IDX_W     = ADDR_WIDTH - 2;

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic                                we;
        logic [IDX_W-1:0]                    idx;
        logic [NUM_LANES-1:0]                be;
        logic [NUM_LANES-1:0][VEC_W-1:0]     wdata;
    } req_t;

    state_t               state;
    logic                 last_b;
    logic                 own_b_q;
    logic                 we_q;
    logic                 oor_q;
    logic                 pick_b;
    logic                 in_range;
    req_t                 req_a, req_b, req_w;
    logic [NUM_LANES-1:0] lane_wr, lane_rd;

    always_comb begin
        req_a    = '{we: A_WE, idx: A_ADDR[ADDR_WIDTH-1:2], be: A_BE, wdata: A_WDATA};
        req_b    = '{we: B_WE, idx: B_ADDR[ADDR_WIDTH-1:2], be: B_BE, wdata: B_WDATA};
        // On a tie the requester that did not win last time goes first.
        pick_b   = B_REQ && (!A_REQ || !last_b);
        req_w    = pick_b ? req_b : req_a;
        in_range = (32'(req_w.idx) < MEM_WORDS);
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dmem_lane u_lane (
            .in_range (in_range),
            .we       (req_w.we),
            .be       (req_w.be[i]),
            .wr_en    (lane_wr[i]),
            .rd_en    (lane_rd[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            last_b       <= 1'b1;
            own_b_q      <= 1'b0;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            A_GNT        <= 1'b0;
            A_RVALID     <= 1'b0;
            A_RDATA      <= '0;
            A_ERR        <= 1'b0;
            B_GNT        <= 1'b0;
            B_RVALID     <= 1'b0;
            B_RDATA      <= '0;
            B_ERR        <= 1'b0;
            MEM_W_ADDR   <= '0;
            MEM_R_ADDR   <= '0;
            MEM_WRITE_EN <= '0;
            MEM_READ_EN  <= '0;
            MEM_DIN      <= '0;
        end else begin
            A_GNT    <= 1'b0;
            B_GNT    <= 1'b0;
            A_RVALID <= 1'b0;
            B_RVALID <= 1'b0;
            A_ERR    <= 1'b0;
            B_ERR    <= 1'b0;
            case (state)
                IDLE: begin
                    if (A_REQ || B_REQ) begin
                        last_b       <= pick_b;
                        own_b_q      <= pick_b;
                        we_q         <= req_w.we;
                        oor_q        <= !in_range;
                        A_GNT        <= !pick_b;
                        B_GNT        <= pick_b;
                        MEM_R_ADDR   <= {req_w.idx, 2'b00};
                        MEM_W_ADDR   <= {req_w.idx, 2'b00};
                        MEM_DIN      <= req_w.wdata;
                        MEM_READ_EN  <= lane_rd;
                        MEM_WRITE_EN <= lane_wr;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Banks updated MEM_DOUT on the falling edge inside the access cycle.
                    MEM_READ_EN  <= '0;
                    MEM_WRITE_EN <= '0;
                    state        <= IDLE;
                    if (!we_q) begin
                        if (own_b_q) begin
                            B_RDATA  <= oor_q ? 32'h0 : MEM_DOUT;
                            B_RVALID <= 1'b1;
                        end else begin
                            A_RDATA  <= oor_q ? 32'h0 : MEM_DOUT;
                            A_RVALID <= 1'b1;
                        end
                    end
                    A_ERR <= oor_q && !own_b_q;
                    B_ERR <= oor_q && own_b_q;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a negedge byte-lane BRAM model on the memory side.

module tb_dmem_arbiter;
    logic        CLK = 1'b0;
    logic        RST;
    logic        A_REQ, A_WE, B_REQ, B_WE;
    logic [12:0] A_ADDR, B_ADDR;
    logic [3:0]  A_BE, B_BE;
    logic [31:0] A_WDATA, B_WDATA;
    logic        A_GNT, A_RVALID, A_ERR, B_GNT, B_RVALID, B_ERR;
    logic [31:0] A_RDATA, B_RDATA;
    logic [12:0] MEM_W_ADDR, MEM_R_ADDR;
    logic [3:0]  MEM_WRITE_EN, MEM_READ_EN;
    logic [31:0] MEM_DIN, MEM_DOUT;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:2047];

    dmem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_BE(A_BE), .A_WDATA(A_WDATA),
        .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA), .A_ERR(A_ERR),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_BE(B_BE), .B_WDATA(B_WDATA),
        .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA), .B_ERR(B_ERR),
        .MEM_W_ADDR(MEM_W_ADDR), .MEM_R_ADDR(MEM_R_ADDR),
        .MEM_WRITE_EN(MEM_WRITE_EN), .MEM_READ_EN(MEM_READ_EN),
        .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
    );

    always #5 CLK = ~CLK;

    // Four byte-wide banks acting on the falling edge; contents seeded during reset.
    always @(negedge CLK) begin
        if (RST) begin
            mem[4]   <= 32'h11223344;
            mem[2]   <= 32'h01020304;
            MEM_DOUT <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (MEM_WRITE_EN[i]) mem[MEM_W_ADDR[12:2]][8*i +: 8] <= MEM_DIN[8*i +: 8];
                if (MEM_READ_EN[i])  MEM_DOUT[8*i +: 8] <= mem[MEM_R_ADDR[12:2]][8*i +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [12:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
        A_REQ = req; A_WE = we; A_ADDR = addr; A_BE = be; A_WDATA = wd;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [12:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
        B_REQ = req; B_WE = we; B_ADDR = addr; B_BE = be; B_WDATA = wd;
    endtask

    initial begin
        RST = 1'b1;
        drive_a(0, 0, 13'h0, 4'h0, 32'h0);
        drive_b(0, 0, 13'h0, 4'h0, 32'h0);
        tick(); tick();
        chk("rst_a_gnt",   {31'b0, A_GNT},   32'h0);
        chk("rst_b_gnt",   {31'b0, B_GNT},   32'h0);
        chk("rst_rd_en",   {28'b0, MEM_READ_EN},  32'h0);
        chk("rst_wr_en",   {28'b0, MEM_WRITE_EN}, 32'h0);
        chk("rst_a_rdata", A_RDATA, 32'h0);
        chk("rst_r_addr",  {19'b0, MEM_R_ADDR}, 32'h0);
        RST = 1'b0;
        tick();

        // Single load from word 4.
        drive_a(1, 0, 13'h0010, 4'h0, 32'h0);
        tick();
        chk("ld_a_gnt",  {31'b0, A_GNT}, 32'h1);
        chk("ld_b_gnt",  {31'b0, B_GNT}, 32'h0);
        chk("ld_rd_en",  {28'b0, MEM_READ_EN}, 32'hF);
        chk("ld_r_addr", {19'b0, MEM_R_ADDR}, 32'h10);
        chk("ld_rv_early", {31'b0, A_RVALID}, 32'h0);
        drive_a(0, 0, 13'h0, 4'h0, 32'h0);
        tick();
        chk("ld_rvalid", {31'b0, A_RVALID}, 32'h1);
        chk("ld_rdata",  A_RDATA, 32'h11223344);
        chk("ld_rd_off", {28'b0, MEM_READ_EN}, 32'h0);
        chk("ld_err",    {31'b0, A_ERR}, 32'h0);
        tick();
        chk("ld_rv_pulse", {31'b0, A_RVALID}, 32'h0);

        // Byte store by B to word 2, lanes 0 and 2.
        drive_b(1, 1, 13'h0008, 4'b0101, 32'hAABBCCDD);
        tick();
        chk("st_b_gnt",  {31'b0, B_GNT}, 32'h1);
        chk("st_wr_en",  {28'b0, MEM_WRITE_EN}, 32'h5);
        chk("st_din",    MEM_DIN, 32'hAABBCCDD);
        chk("st_w_addr", {19'b0, MEM_W_ADDR}, 32'h8);
        drive_b(0, 0, 13'h0, 4'h0, 32'h0);
        tick();
        chk("st_no_rv",  {31'b0, B_RVALID}, 32'h0);
        chk("st_no_err", {31'b0, B_ERR}, 32'h0);
        chk("st_wr_off", {28'b0, MEM_WRITE_EN}, 32'h0);

        // Contention: B went last, so A leads and grants alternate every two cycles.
        drive_a(1, 0, 13'h0010, 4'h0, 32'h0);
        drive_b(1, 0, 13'h0008, 4'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("ct_a_gnt%0d", i), {31'b0, A_GNT}, {31'b0, (i % 4) == 0});
            chk($sformatf("ct_b_gnt%0d", i), {31'b0, B_GNT}, {31'b0, (i % 4) == 2});
            chk($sformatf("ct_a_rv%0d", i), {31'b0, A_RVALID}, {31'b0, (i % 4) == 1});
            chk($sformatf("ct_b_rv%0d", i), {31'b0, B_RVALID}, {31'b0, (i % 4) == 3});
            if (i == 7) chk("ct_b_rdata", B_RDATA, 32'h01BB03DD);
        end
        drive_a(0, 0, 13'h0, 4'h0, 32'h0);
        drive_b(0, 0, 13'h0, 4'h0, 32'h0);
        tick();

        // Out-of-range load by A: word index 1024.
        drive_a(1, 0, 13'h1000, 4'h0, 32'h0);
        tick();
        chk("oor_a_gnt", {31'b0, A_GNT}, 32'h1);
        chk("oor_rd_en", {28'b0, MEM_READ_EN}, 32'h0);
        drive_a(0, 0, 13'h0, 4'h0, 32'h0);
        tick();
        chk("oor_a_err", {31'b0, A_ERR}, 32'h1);
        chk("oor_a_rv",  {31'b0, A_RVALID}, 32'h1);
        chk("oor_rdata", A_RDATA, 32'h0);
        chk("oor_b_err", {31'b0, B_ERR}, 32'h0);

        // Out-of-range store by B: error only, no enables, no RVALID.
        drive_b(1, 1, 13'h1FFC, 4'hF, 32'hDEADBEEF);
        tick();
        chk("oors_wr_en", {28'b0, MEM_WRITE_EN}, 32'h0);
        drive_b(0, 0, 13'h0, 4'h0, 32'h0);
        tick();
        chk("oors_b_err", {31'b0, B_ERR}, 32'h1);
        chk("oors_b_rv",  {31'b0, B_RVALID}, 32'h0);

        // Store with no byte enables still gets granted and completes quietly.
        drive_b(1, 1, 13'h0008, 4'h0, 32'h12345678);
        tick();
        chk("be0_gnt",   {31'b0, B_GNT}, 32'h1);
        chk("be0_wr_en", {28'b0, MEM_WRITE_EN}, 32'h0);
        drive_b(0, 0, 13'h0, 4'h0, 32'h0);
        tick();
        chk("be0_err", {31'b0, B_ERR}, 32'h0);

        // Back-to-back loads with REQ held: one access per two cycles.
        drive_a(1, 0, 13'h0010, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("bb_gnt%0d", i), {31'b0, A_GNT}, {31'b0, (i % 2) == 0});
            chk($sformatf("bb_rv%0d", i),  {31'b0, A_RVALID}, {31'b0, (i % 2) == 1});
        end
        chk("bb_rdata", A_RDATA, 32'h11223344);
        drive_a(0, 0, 13'h0, 4'h0, 32'h0);
        tick();

        // Reset during the access cycle drops the read; A went last, reset restores A priority.
        drive_a(1, 0, 13'h0010, 4'h0, 32'h0);
        tick();
        chk("mr_gnt", {31'b0, A_GNT}, 32'h1);
        drive_a(0, 0, 13'h0, 4'h0, 32'h0);
        RST = 1'b1;
        tick();
        chk("mr_no_rv",  {31'b0, A_RVALID}, 32'h0);
        chk("mr_rdata",  A_RDATA, 32'h0);
        chk("mr_rd_en",  {28'b0, MEM_READ_EN}, 32'h0);
        chk("mr_gnt_lo", {31'b0, A_GNT}, 32'h0);
        RST = 1'b0;
        tick();
        chk("mr_no_rv2", {31'b0, A_RVALID}, 32'h0);
        drive_a(1, 0, 13'h0010, 4'h0, 32'h0);
        drive_b(1, 0, 13'h0008, 4'h0, 32'h0);
        tick();
        chk("mr_tie_a", {31'b0, A_GNT}, 32'h1);
        chk("mr_tie_b", {31'b0, B_GNT}, 32'h0);
        drive_a(0, 0, 13'h0, 4'h0, 32'h0);
        drive_b(0, 0, 13'h0, 4'h0, 32'h0);
        tick();
        chk("mr_tie_rv", {31'b0, A_RVALID}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
